// File: rtl/srm_pkg.sv
// Shared definitions for the SRM instruction sequencer: state encodings,
// instruction width and the MOV/ALU opcode fields used to build programs.
package srm_pkg;

    localparam int IW = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_START   = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_WAIT_HI = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_FETCH   = ST_FETCH,
        S_LOAD    = ST_LOAD,
        S_START   = ST_START,
        S_WAIT_LO = ST_WAIT_LO,
        S_WAIT_HI = ST_WAIT_HI,
        S_DONE    = ST_DONE
    } seq_state_e;

    // Instruction layout: [15:13] opcode, [12:11] op, then operand fields.
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    function automatic logic [IW-1:0] enc_mov_imm(input logic [2:0] rn, input logic [7:0] imm8);
        return {OPC_MOV, OP_MOV_IMM, rn, imm8};
    endfunction

endpackage

// File: rtl/srm_prog_mem.sv
// Program store for the sequencer: one write port, one registered read port.
// Contents are deliberately not reset so a program survives a reset pulse.
module srm_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/srm_instr_sequencer.sv
// Replays a stored program into the SRM cpu (in/load/s/w handshake).
// Build option: define SRM_SEQ_WDOG_EN to add the wait-state watchdog and fault output.
module srm_instr_sequencer
    import srm_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int IW          = srm_pkg::IW,
    parameter int WDOG_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    input  logic          cpu_w
);

`ifdef SRM_SEQ_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    localparam int          WW      = $clog2(WDOG_CYCLES + 1);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    seq_state_e    state;
    logic [AW:0]   len;
    logic [AW:0]   sat_len;
    logic          last;
    logic          in_vld;
    logic          fault_q;
    logic [WW-1:0] wdog;
    logic [IW-1:0] rd_data;

    srm_prog_mem #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_mem (
        .clk   (clk),
        .we    (prog_we & ~busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (state == S_FETCH),
        .raddr (pc),
        .rdata (rd_data)
    );

    assign sat_len = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign last    = ({1'b0, pc} == len - (AW+1)'(1));

    // The read register has no reset, so cpu_in is masked until a fetch has landed.
    assign cpu_in = in_vld ? rd_data : '0;
    assign fault  = fault_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            len      <= '0;
            pc       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault_q  <= 1'b0;
            in_vld   <= 1'b0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            wdog     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    len     <= sat_len;
                    pc      <= '0;
                    done    <= 1'b0;
                    fault_q <= 1'b0;
                    busy    <= 1'b1;
                    in_vld  <= 1'b0;
                    state   <= (sat_len == '0) ? S_DONE : S_FETCH;
                end
                // The read is reissued every cycle here; the word that lands on exit is mem[pc].
                S_FETCH: if (cpu_w) begin
                    in_vld   <= 1'b1;
                    cpu_load <= 1'b1;
                    state    <= S_LOAD;
                end
                S_LOAD: begin
                    cpu_load <= 1'b0;
                    cpu_s    <= 1'b1;
                    state    <= S_START;
                end
                S_START: begin
                    cpu_s <= 1'b0;
                    wdog  <= '0;
                    state <= S_WAIT_LO;
                end
                S_WAIT_LO: if (!cpu_w) state <= S_WAIT_HI;
                S_WAIT_HI: if (cpu_w) begin
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Watchdog overrides the wait-state transitions when it expires.
            if (WDOG_EN && (state == S_WAIT_LO || state == S_WAIT_HI)) begin
                if (wdog == WW'(WDOG_CYCLES - 1)) begin
                    fault_q <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_srm_instr_sequencer.sv
// Scoreboard bench for srm_instr_sequencer with a cpu stub that also executes MOV.
module tb_srm_instr_sequencer;
    import srm_pkg::*;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          busy, done, fault, cpu_load, cpu_s;
    logic [AW-1:0] pc;
    logic [15:0]   cpu_in;
    logic          cpu_w = 1'b1;

    srm_instr_sequencer #(.DEPTH(16), .AW(AW), .IW(16), .WDOG_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .busy(busy),
        .done(done), .fault(fault), .pc(pc), .cpu_in(cpu_in), .cpu_load(cpu_load),
        .cpu_s(cpu_s), .cpu_w(cpu_w)
    );

    always #5 clk = ~clk;

    // cpu stub: w drops the cycle after s and rises 3 cycles later; MOV is executed on s.
    logic        hang = 1'b0;
    int          wcnt = 0;
    logic [15:0] ir = '0;
    logic [15:0] rf [8];

    always @(posedge clk) begin
        if (cpu_load) ir <= cpu_in;
        if (cpu_s) begin
            if (!hang) begin
                cpu_w <= 1'b0;
                wcnt  <= 3;
            end
            if (ir[15:13] == OPC_MOV && ir[12:11] == OP_MOV_IMM)
                rf[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
            else if (ir[15:13] == OPC_MOV && ir[12:11] == OP_MOV_REG)
                rf[ir[7:5]] <= rf[ir[2:0]];
        end else if (wcnt > 0) begin
            wcnt <= wcnt - 1;
            if (wcnt == 1) cpu_w <= 1'b1;
        end
    end

    // kind: 0 status vector, 1 {R3,R0}, 2 done count, 3 load count, 4 pending expectations
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } snap_t;

    snap_t       snaps[$];
    logic [15:0] exp_in[$];
    logic [3:0]  exp_pc[$];
    int          tests = 0;
    int          fails = 0;
    int          load_cnt = 0;
    int          done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a load, a done edge or a snapshot request.
    initial begin
        logic        done_q;
        logic [15:0] last_in;
        logic [31:0] act;
        snap_t       sn;
        done_q  = 1'b0;
        last_in = '0;
        forever begin
            @(negedge clk);
            if (cpu_load && cpu_s) check("strobe_overlap", {cpu_load, cpu_s}, 32'h0);
            if (cpu_load) begin
                load_cnt++;
                if (exp_in.size() == 0) check("unexpected_load", cpu_in, 32'hFFFF_FFFF);
                else check("cpu_in", cpu_in, exp_in.pop_front());
                last_in = cpu_in;
            end
            if (cpu_s) check("cpu_in_stable", cpu_in, last_in);
            if (done && !done_q) begin
                done_cnt++;
                if (exp_pc.size() == 0) check("unexpected_done", pc, 32'hFFFF_FFFF);
                else check("done_pc", pc, exp_pc.pop_front());
            end
            done_q = done;
            while (snaps.size() > 0) begin
                sn = snaps.pop_front();
                case (sn.kind)
                    0:       act = {7'd0, busy, done, fault, cpu_load, cpu_s, pc, cpu_in};
                    1:       act = {rf[3], rf[0]};
                    2:       act = done_cnt;
                    3:       act = load_cnt;
                    default: act = exp_in.size() + exp_pc.size();
                endcase
                check(sn.name, act, sn.exp);
            end
        end
    end

    int exp_done = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic push_st(input string nm, input logic b, input logic d, input logic f,
                           input logic l, input logic s, input logic [3:0] p, input logic [15:0] c);
        snaps.push_back('{name: nm, kind: 0, exp: {7'd0, b, d, f, l, s, p, c}});
    endtask

    task automatic push_k(input string nm, input int k, input logic [31:0] e);
        snaps.push_back('{name: nm, kind: k, exp: e});
    endtask

    task automatic go(input logic [AW:0] n);
        prog_len = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int bound);
        exp_done++;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt >= exp_done) break;
        end
        push_k(nm, 2, exp_done);
    endtask

    initial begin
        int base;
        reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0;  start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        push_st("reset_state", 0, 0, 0, 0, 0, 4'd0, 16'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Three-instruction run
        wr(0, 16'hD008); wr(1, 16'hD400); wr(2, 16'hD7FF);
        exp_in.push_back(16'hD008); exp_in.push_back(16'hD400); exp_in.push_back(16'hD7FF);
        exp_pc.push_back(4'd2);
        go(3);
        push_st("busy_after_start", 1, 0, 0, 0, 0, 4'd0, 16'h0);
        wait_done("run3_done", 200);
        push_st("idle_after_run3", 0, 1, 0, 0, 0, 4'd2, 16'hD7FF);

        // MOV R0,#8 ; MOV R3,R0 -- second word written in the same cycle as start
        wr(0, 16'hD008);
        exp_in.push_back(16'hD008); exp_in.push_back(16'hC060);
        exp_pc.push_back(4'd1);
        prog_addr = 4'd1; prog_data = 16'hC060; prog_we = 1'b1;
        go(2);
        prog_we = 1'b0;
        wait_done("mov_done", 200);
        push_k("mov_regs", 1, {16'd8, 16'd8});

        // Zero-length run
        base = load_cnt;
        exp_pc.push_back(4'd0);
        go(0);
        push_st("len0_cycle1", 1, 0, 0, 0, 0, 4'd0, 16'h0);
        tick();
        push_st("len0_cycle2", 0, 1, 0, 0, 0, 4'd0, 16'h0);
        wait_done("len0_done", 20);
        push_k("len0_no_loads", 3, base);

        // start and prog_we while busy are ignored
        exp_in.push_back(16'hD008); exp_in.push_back(16'hC060); exp_in.push_back(16'hD7FF);
        exp_pc.push_back(4'd2);
        go(3);
        tick(); tick();
        prog_addr = 4'd2; prog_data = 16'h1234; prog_we = 1'b1; prog_len = 5'd1; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_done("busy_ignore_done", 200);
        repeat (10) tick();
        push_k("no_extra_done", 2, exp_done);

        // prog_len above DEPTH saturates to the full memory
        for (int i = 0; i < 16; i++) begin
            wr(AW'(i), 16'hA000 + 16'(i));
            exp_in.push_back(16'hA000 + 16'(i));
        end
        exp_pc.push_back(4'd15);
        go(5'd20);
        wait_done("sat_done", 600);
        push_st("idle_after_sat", 0, 1, 0, 0, 0, 4'd15, 16'hA00F);

        // Reset during WAIT_HI of the second instruction
        base = load_cnt;
        exp_in.push_back(16'hA000); exp_in.push_back(16'hA001); exp_in.push_back(16'hA002);
        exp_pc.push_back(4'd2);
        go(3);
        for (int i = 0; i < 100 && load_cnt < base + 2; i++) tick();
        push_k("reached_instr2", 3, base + 2);
        for (int i = 0; i < 20 && !cpu_s; i++) tick();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_in.delete();
        exp_pc.delete();
        push_st("async_reset", 0, 0, 0, 0, 0, 4'd0, 16'h0);
        tick();
        reset_n = 1'b1;
        tick();
        exp_in.push_back(16'hA000); exp_in.push_back(16'hA001); exp_in.push_back(16'hA002);
        exp_pc.push_back(4'd2);
        go(3);
        wait_done("rerun_done", 200);
        push_st("idle_after_rerun", 0, 1, 0, 0, 0, 4'd2, 16'hA002);

`ifdef SRM_SEQ_WDOG_EN
        // cpu never leaves its wait state: watchdog ends the run with fault
        hang = 1'b1;
        exp_in.push_back(16'hA000);
        go(1);
        for (int i = 0; i < 20 && !cpu_s; i++) tick();
        tick();
        repeat (63) tick();
        push_st("wdog_cycle63", 1, 0, 0, 0, 0, 4'd0, 16'hA000);
        tick();
        push_st("wdog_fault", 0, 0, 1, 0, 0, 4'd0, 16'hA000);
        hang = 1'b0;
        repeat (5) tick();
        push_k("wdog_no_done", 2, exp_done);
`endif

        repeat (3) tick();
        push_k("scoreboard_drained", 4, 0);
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
